id_ex_stage: RTL

- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded control, operands and register numbers from ID. Drives ID_EX_RegisterRs/Rt into the forwarding unit and EX, and control into EX/MEM.
- Issues PC/IF-ID write-enables, inserts bubbles on load-use hazards and branch flushes, and freezes on memory stalls.

---
 rtl/mips_pipe_pkg.sv | 44 ++++
 rtl/id_ex_stage_hazard_detect.sv | 44 ++++
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline: ALUOp and
// forwarding-select encodings, per-stage control bundles and the bubble value.
package mips_pipe_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int ALUOP_W_DEF    = 2;

  localparam logic [ALUOP_W_DEF-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W_DEF-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W_DEF-1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                   reg_dst;
    logic [ALUOP_W_DEF-1:0] alu_op;
    logic                   alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  // A bubble carries no side effects: no write-back, no memory access.
  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [7:0] STALL_MAX = 8'hFF;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection and front-end write-enable generation.
// Purely combinational; sees the registered EX-stage copy and the ID fields.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  reset,
  input  logic                  mem_stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  load_use,
  output logic                  pc_write,
  output logic                  if_id_write
);

  // A load in EX whose destination feeds the instruction in ID; $zero never counts.
  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rt != '0) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

  // Front-end enables follow the same priority as the ID/EX register update.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if (reset) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (flush) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch-flush
// bubbles, memory-stall freeze and a saturating bubble counter.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int ALUOP_W    = ALUOP_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_stall,
  input  logic                  flush,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemWrite,
  input  logic                  ID_MemtoReg,
  input  logic                  ID_ALUSrc,
  input  logic                  ID_RegDst,
  input  logic [ALUOP_W-1:0]    ID_ALUOp,
  input  logic [DATA_W-1:0]     ID_ReadData1,
  input  logic [DATA_W-1:0]     ID_ReadData2,
  input  logic [DATA_W-1:0]     ID_SignImm,
  input  logic [DATA_W-1:0]     ID_PCPlus4,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRd,
  output logic                  ID_EX_RegWrite,
  output logic                  ID_EX_MemRead,
  output logic                  ID_EX_MemWrite,
  output logic                  ID_EX_MemtoReg,
  output logic                  ID_EX_ALUSrc,
  output logic                  ID_EX_RegDst,
  output logic [ALUOP_W-1:0]    ID_EX_ALUOp,
  output logic [DATA_W-1:0]     ID_EX_ReadData1,
  output logic [DATA_W-1:0]     ID_EX_ReadData2,
  output logic [DATA_W-1:0]     ID_EX_SignImm,
  output logic [DATA_W-1:0]     ID_EX_PCPlus4,
  output logic [REG_ADDR_W-1:0] ID_EX_RegisterRs,
  output logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
  output logic [REG_ADDR_W-1:0] ID_EX_RegisterRd,
  output logic                  ID_EX_Valid,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic [7:0]            stall_count
);

  ctrl_t                 ctrl_q;
  ctrl_t                 ctrl_d;
  logic                  valid_q;
  logic [DATA_W-1:0]     rd1_q, rd2_q, imm_q, pc4_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic [7:0]            stall_q;
  logic                  load_use;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .reset       (reset),
    .mem_stall   (mem_stall),
    .flush       (flush),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem.mem_read),
    .ex_rt       (rt_q),
    .id_rs       (IF_ID_RegisterRs),
    .id_rt       (IF_ID_RegisterRt),
    .load_use    (load_use),
    .pc_write    (PCWrite),
    .if_id_write (IF_ID_Write)
  );

  // Pack the decoded ID control into the per-stage bundle.
  always_comb begin
    ctrl_d               = CTRL_NOP;
    ctrl_d.ex.reg_dst    = ID_RegDst;
    ctrl_d.ex.alu_op     = ID_ALUOp;
    ctrl_d.ex.alu_src    = ID_ALUSrc;
    ctrl_d.mem.mem_read  = ID_MemRead;
    ctrl_d.mem.mem_write = ID_MemWrite;
    ctrl_d.wb.reg_write  = ID_RegWrite;
    ctrl_d.wb.mem_to_reg = ID_MemtoReg;
  end

  // Priority update: stall hold > flush bubble > load-use bubble > capture.
  // Bubbles also zero the register numbers so forwarding can never match them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      stall_q <= '0;
    end else if (mem_stall) begin
      ctrl_q  <= ctrl_q;
      valid_q <= valid_q;
    end else if (flush || load_use) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      if (!flush && stall_q != STALL_MAX) begin
        stall_q <= stall_q + 8'd1;
      end
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= 1'b1;
      rd1_q   <= ID_ReadData1;
      rd2_q   <= ID_ReadData2;
      imm_q   <= ID_SignImm;
      pc4_q   <= ID_PCPlus4;
      rs_q    <= IF_ID_RegisterRs;
      rt_q    <= IF_ID_RegisterRt;
      rd_q    <= IF_ID_RegisterRd;
    end
  end

  assign ID_EX_RegWrite   = ctrl_q.wb.reg_write;
  assign ID_EX_MemtoReg   = ctrl_q.wb.mem_to_reg;
  assign ID_EX_MemRead    = ctrl_q.mem.mem_read;
  assign ID_EX_MemWrite   = ctrl_q.mem.mem_write;
  assign ID_EX_RegDst     = ctrl_q.ex.reg_dst;
  assign ID_EX_ALUOp      = ctrl_q.ex.alu_op;
  assign ID_EX_ALUSrc     = ctrl_q.ex.alu_src;
  assign ID_EX_ReadData1  = rd1_q;
  assign ID_EX_ReadData2  = rd2_q;
  assign ID_EX_SignImm    = imm_q;
  assign ID_EX_PCPlus4    = pc4_q;
  assign ID_EX_RegisterRs = rs_q;
  assign ID_EX_RegisterRt = rt_q;
  assign ID_EX_RegisterRd = rd_q;
  assign ID_EX_Valid      = valid_q;
  assign stall_count      = stall_q;

endmodule
